// File: rtl/coder_arb_pkg.sv
// coder_arb_pkg: arbiter state encoding, byte width and lane-index width helper
package coder_arb_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;
  function automatic int lane_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction
endpackage

// File: rtl/coder_lane_arbiter_if.sv
// coder_lane_arbiter_if: per-lane byte streams in, merged coder_out channel out
interface coder_lane_arbiter_if import coder_arb_pkg::*; #(
  parameter int LANES = 8,
  parameter int IDX_W = 8
);
  logic [LANES-1:0] in_valid;
  logic [BYTE_W*LANES-1:0] in_byte;
  logic [LANES-1:0] in_last;
  logic [LANES-1:0] in_ready;
  logic out_valid;
  logic [BYTE_W-1:0] out_byte;
  logic [IDX_W-1:0] out_idx;
  logic out_last;
  logic out_ready;
  modport master (
    output in_valid, in_byte, in_last, out_ready,
    input in_ready, out_valid, out_byte, out_idx, out_last
  );
  modport slave (
    input in_valid, in_byte, in_last, out_ready,
    output in_ready, out_valid, out_byte, out_idx, out_last
  );
endinterface

// File: rtl/coder_lane_arbiter_rr_pick.sv
// rr_pick: combinational round-robin first-set finder starting the scan at ptr
module rr_pick import coder_arb_pkg::*; #(
  parameter int LANES = 8,
  localparam int LW = lane_w(LANES)
) (
  input logic [LANES-1:0] i_req,
  input logic [LW-1:0] i_ptr,
  output logic o_hit,
  output logic [LW-1:0] o_idx
);
  function automatic int wrap(input int v);
    return (v >= LANES) ? v - LANES : v;
  endfunction
  // Scan farthest offset first so the nearest request to ptr wins last
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (i_req[LW'(wrap(int'(i_ptr) + k))]) begin
        o_hit = 1'b1;
        o_idx = LW'(wrap(int'(i_ptr) + k));
      end
    end
  end
endmodule

// File: rtl/coder_lane_arbiter.sv
// coder_lane_arbiter: round-robin, burst-bounded merge of coder lanes onto one output
// CODER_ARB_STATS_EN adds per-lane accepted-byte and output-stall counters
module coder_lane_arbiter import coder_arb_pkg::*; #(
  parameter int LANES = 8,
  parameter int MAX_BURST = 16,
  parameter int IDX_W = 8,
  localparam int LW = lane_w(LANES),
  localparam int BW = $clog2(MAX_BURST) + 1
) (
  input logic clk,
  input logic rst_n,
  coder_lane_arbiter_if.slave bus
`ifdef CODER_ARB_STATS_EN
  ,
  output logic [32*LANES-1:0] stat_bytes,
  output logic [31:0] stat_stall
`endif
);
  localparam logic [LANES-1:0] ALL = '1;
  state_t r_state, w_state_nxt;
  logic [LW-1:0] r_ptr, r_grant, w_pick;
  logic [BW-1:0] r_burst_cnt;
  logic [LANES-1:0] r_done_mask, w_done_nxt, w_grant_oh;
  logic w_hit, w_out_free, w_gv, w_gl, w_accept, w_end, w_restart;
  logic [BYTE_W-1:0] w_gb;
  logic r_out_valid, r_out_last;
  logic [BYTE_W-1:0] r_out_byte;
  logic [IDX_W-1:0] r_out_idx;

  rr_pick #(.LANES(LANES)) u_pick (
    .i_req(bus.in_valid & ~r_done_mask),
    .i_ptr(r_ptr),
    .o_hit(w_hit),
    .o_idx(w_pick)
  );

  always_comb begin
    w_out_free = !r_out_valid || bus.out_ready;
    w_grant_oh = LANES'(1) << r_grant;
    w_gv = bus.in_valid[r_grant];
    w_gl = bus.in_last[r_grant];
    w_gb = bus.in_byte[BYTE_W*r_grant +: BYTE_W];
    w_accept = r_state == GRANT && w_out_free && w_gv;
    w_done_nxt = (w_accept && w_gl) ? (r_done_mask | w_grant_oh) : r_done_mask;
    // Without an accept, a free output with an idle granted lane is a bubble release
    w_end = r_state == GRANT && (w_accept ? (w_gl || r_burst_cnt == BW'(MAX_BURST - 1)) : w_out_free);
    w_restart = r_state == DONE && r_out_valid && bus.out_ready && r_out_last;
    bus.in_ready = (r_state == GRANT && w_out_free) ? w_grant_oh : '0;
    w_state_nxt = r_state;
    if (r_state == IDLE && w_hit) w_state_nxt = GRANT;
    if (w_end) w_state_nxt = (w_done_nxt == ALL) ? DONE : IDLE;
    if (w_restart) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_grant <= '0;
      r_burst_cnt <= '0;
      r_done_mask <= '0;
      r_out_valid <= 1'b0;
      r_out_byte <= '0;
      r_out_idx <= '0;
      r_out_last <= 1'b0;
    end else begin
      if (r_state == IDLE && w_hit) begin
        r_grant <= w_pick;
        r_burst_cnt <= '0;
      end
      if (w_accept) begin
        r_burst_cnt <= r_burst_cnt + 1'b1;
        r_out_byte <= w_gb;
        r_out_idx <= IDX_W'(r_grant);
        r_out_last <= w_gl && w_done_nxt == ALL;
      end
      r_out_valid <= w_accept || (r_out_valid && !bus.out_ready);
      r_done_mask <= w_restart ? '0 : w_done_nxt;
      if (w_end) r_ptr <= (r_grant == LW'(LANES - 1)) ? '0 : r_grant + 1'b1;
      if (w_restart) r_ptr <= '0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_byte = r_out_byte;
  assign bus.out_idx = r_out_idx;
  assign bus.out_last = r_out_last;

`ifdef CODER_ARB_STATS_EN
  logic [31:0] r_stat_bytes [LANES];
  logic [31:0] r_stat_stall;
  always_ff @(posedge clk) begin
    if (!rst_n || w_restart) begin
      for (int i = 0; i < LANES; i++) r_stat_bytes[i] <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_accept && r_stat_bytes[r_grant] != '1) r_stat_bytes[r_grant] <= r_stat_bytes[r_grant] + 1'b1;
      if (r_out_valid && !bus.out_ready && r_stat_stall != '1) r_stat_stall <= r_stat_stall + 1'b1;
    end
  end
  for (genvar g = 0; g < LANES; g++) begin : g_stat
    assign stat_bytes[32*g +: 32] = r_stat_bytes[g];
  end
  assign stat_stall = r_stat_stall;
`endif
endmodule

// File: tb/tb_coder_lane_arbiter.sv
// tb_coder_lane_arbiter: directed + randomized jobs checked against a round-robin sequence model
module tb_coder_lane_arbiter;
  import coder_arb_pkg::*;
  localparam int LANES = 8, MAX_BURST = 16, IDX_W = 8, GAP = 10, BUDGET = 4000;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  coder_lane_arbiter_if #(.LANES(LANES), .IDX_W(IDX_W)) bus ();
`ifdef CODER_ARB_STATS_EN
  logic [32*LANES-1:0] stat_bytes;
  logic [31:0] stat_stall;
`endif
  coder_lane_arbiter #(.LANES(LANES), .MAX_BURST(MAX_BURST), .IDX_W(IDX_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef CODER_ARB_STATS_EN
    , .stat_bytes(stat_bytes),
    .stat_stall(stat_stall)
`endif
  );

  int n_assert = 0, n_fail = 0;
  int len[LANES], brk[LANES];
  logic [7:0] data[LANES][64];
  int q_idx[$];
  logic [7:0] q_byte[$];
  bit q_last[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected order: scan from ptr for a lane with bytes left, take up to MAX_BURST
  // bytes (fewer at its last byte or at a planned valid gap), then move past it
  task automatic build_model();
    int rem[LANES], s[LANES];
    int p, lane, n;
    bit found, stop;
    q_idx.delete(); q_byte.delete(); q_last.delete();
    for (int l = 0; l < LANES; l++) begin rem[l] = len[l]; s[l] = 0; end
    p = 0;
    lane = 0;
    forever begin
      found = 0;
      for (int k = 0; k < LANES && !found; k++) begin
        lane = (p + k) % LANES;
        if (rem[lane] > 0) found = 1;
      end
      if (!found) break;
      n = 0;
      stop = 0;
      while (!stop) begin
        q_idx.push_back(lane);
        q_byte.push_back(data[lane][s[lane]]);
        q_last.push_back(1'b0);
        s[lane]++; rem[lane]--; n++;
        stop = rem[lane] == 0 || n == MAX_BURST || s[lane] == brk[lane];
      end
      p = (lane + 1) % LANES;
    end
    q_last[q_last.size() - 1] = 1'b1;
  endtask

  task automatic run_job(input int abort_after, input int rmode);
    int drv[LANES], gcnt[LANES];
    int got, cyc, stalls, total;
    bit fin, pv, pvr, pl;
    logic [7:0] pb;
    logic [IDX_W-1:0] pi;
    build_model();
    total = q_idx.size();
    got = 0; cyc = 0; stalls = 0; fin = 0; pv = 0; pvr = 1; pl = 0; pb = '0; pi = '0;
    for (int l = 0; l < LANES; l++) begin drv[l] = 0; gcnt[l] = 0; end
    while (!fin) begin
      @(negedge clk);
      for (int l = 0; l < LANES; l++) begin
        bus.in_valid[l] = drv[l] < len[l] && gcnt[l] == 0;
        bus.in_byte[8*l +: 8] = data[l][drv[l]];
        bus.in_last[l] = drv[l] == len[l] - 1;
      end
      bus.out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? !cyc[0] : ($urandom_range(0, 2) != 0);
      #1;
      check("in_ready_onehot0", 32'($onehot0(bus.in_ready)), 1);
      if (pv && !pvr) begin
        check("hold_valid", 32'(bus.out_valid), 1);
        check("hold_byte", 32'(bus.out_byte), 32'(pb));
        check("hold_idx", 32'(bus.out_idx), 32'(pi));
        check("hold_last", 32'(bus.out_last), 32'(pl));
      end
      if (bus.out_valid && bus.out_ready) begin
        check("model_has_byte", 32'(q_idx.size() > 0), 1);
        if (q_idx.size() > 0) begin
`ifdef CODER_ARB_STATS_EN
          if (q_last[0]) begin
            for (int l = 0; l < LANES; l++) check("stat_bytes", stat_bytes[32*l +: 32], 32'(len[l]));
            check("stat_stall", stat_stall, 32'(stalls));
          end
`endif
          check("out_idx", 32'(bus.out_idx), 32'(q_idx[0]));
          check("out_byte", 32'(bus.out_byte), 32'(q_byte[0]));
          check("out_last", 32'(bus.out_last), 32'(q_last[0]));
          if (q_last[0]) fin = 1;
          void'(q_idx.pop_front()); void'(q_byte.pop_front()); void'(q_last.pop_front());
          got++;
          if (got == abort_after) fin = 1;
        end
      end
      if (bus.out_valid && !bus.out_ready) stalls++;
      for (int l = 0; l < LANES; l++) begin
        if (bus.in_valid[l] && bus.in_ready[l]) begin
          drv[l]++;
          if (drv[l] == brk[l]) gcnt[l] = GAP;
        end else if (gcnt[l] > 0) gcnt[l]--;
      end
      pv = bus.out_valid; pvr = bus.out_ready; pb = bus.out_byte; pi = bus.out_idx; pl = bus.out_last;
      cyc++;
      if (cyc >= BUDGET) begin
        check("job_timeout_left", 32'(q_idx.size()), 0);
        fin = 1;
      end
    end
    if (abort_after == 0) check("byte_count", 32'(got), 32'(total));
  endtask

  task automatic set_job(input int l2, input int l5, input bit rnd);
    for (int l = 0; l < LANES; l++) begin
      len[l] = l == 2 ? l2 : l == 5 ? l5 : 1;
      brk[l] = 0;
      for (int j = 0; j < 64; j++) data[l][j] = rnd ? 8'($urandom) : 8'(8'h10 + l);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_byte", 32'(bus.out_byte), 0);
    check("rst_out_idx", 32'(bus.out_idx), 0);
    check("rst_out_last", 32'(bus.out_last), 0);
    check("rst_in_ready", 32'(bus.in_ready), 0);
  endtask

  initial begin
    bus.in_valid = '0; bus.in_byte = '0; bus.in_last = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    // One last byte per lane, plain lane order, last flag on lane 7
    set_job(1, 1, 0);
    run_job(0, 0);
    // Long lane 2 split into bursts, then the same job under a toggling out_ready
    set_job(40, 5, 1);
    run_job(0, 0);
    set_job(40, 5, 1);
    run_job(0, 1);
    // Lane 1 pauses after 3 bytes: grant moves on, lane 1 finishes on its next turn
    set_job(2, 1, 1);
    len[1] = 6; brk[1] = 3;
    run_job(0, 0);
    // Reset in the middle of a lane 3 burst, then a fresh job from lane 0
    set_job(1, 1, 1);
    len[3] = 20;
    run_job(6, 0);
    @(negedge clk);
    rst_n = 1'b0; bus.in_valid = '0; bus.out_ready = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    set_job(3, 2, 1);
    run_job(0, 0);
    // Randomized job shapes and out_ready backpressure
    for (int t = 0; t < 6; t++) begin
      set_job(1, 1, 1);
      for (int l = 0; l < LANES; l++) len[l] = $urandom_range(1, 40);
      run_job(0, 2);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
